// File: rtl/mul5_pkg.sv
// Shared definitions for the sequential 5x5 multiplier controller.
// Holds the controller state encoding and the fixed datapath dimensions.
package mul5_pkg;

    // One add/shift step per cycle; tied to the 5-bit adder operand width.
    localparam int unsigned N_STEPS = 5;
    localparam int unsigned P_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul5_ctrl_if.sv
// Request/response bundle between the ALU top level and the MUL sequencer.
//   start_i/abort_i : request and cancel strobes toward the sequencer
//   a_i/b_i         : 5-bit unsigned operands, captured with an accepted start
//   ready_o/busy_o  : state decodes (ready = can accept, busy = iterating)
//   done_o/p_o      : one-cycle completion pulse and the held 10-bit product
// master = ALU side, slave = sequencer side.
interface seq_mul5_ctrl_if;
    import mul5_pkg::*;

    logic               start_i;
    logic               abort_i;
    logic [4:0]         a_i;
    logic [4:0]         b_i;
    logic               ready_o;
    logic               busy_o;
    logic               done_o;
    logic [P_WIDTH-1:0] p_o;

    modport master (
        output start_i, abort_i, a_i, b_i,
        input  ready_o, busy_o, done_o, p_o
    );

    modport slave (
        input  start_i, abort_i, a_i, b_i,
        output ready_o, busy_o, done_o, p_o
    );

endinterface

// File: rtl/Add5BitWith6Bit.sv
// Ripple-carry adder: 5-bit operand plus 6-bit operand giving a 7-bit sum.
//   a_i   : 5-bit addend (zero-extended internally)
//   b_i   : 6-bit addend
//   sum_o : 7-bit sum, sum_o[6] is the final carry
module Add5BitWith6Bit (
    input  logic [4:0] a_i,
    input  logic [5:0] b_i,
    output logic [6:0] sum_o
);

    logic [5:0] a_ext_s;
    logic [6:0] carry_s;

    assign a_ext_s    = {1'b0, a_i};
    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < 6; i++) begin : g_fa
        FA u_fa (
            .a_i  (a_ext_s[i]),
            .b_i  (b_i[i]),
            .c_i  (carry_s[i]),
            .s_o  (sum_o[i]),
            .co_o (carry_s[i+1])
        );
    end

    assign sum_o[6] = carry_s[6];

endmodule

// File: rtl/FA.sv
// Single-bit full adder cell used to build the ripple adder.
//   a_i, b_i, c_i : addends and carry in
//   s_o, co_o     : sum and carry out
module FA (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/seq_mul5_ctrl.sv
// Sequential 5x5 unsigned shift-add multiplier controller (ALU MUL sequencer).
// One shared adder is used once per cycle over N_STEPS iterations; a result
// is produced 6 cycles after an accepted start and held until the next one.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of seq_mul5_ctrl_if (start/abort/operands in,
//                ready/busy/done/product out)
module seq_mul5_ctrl
    import mul5_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    seq_mul5_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic [2:0]         count_q, count_d;
    logic [4:0]         m_q, m_d;
    logic [4:0]         q_q, q_d;
    logic [5:0]         acc_q, acc_d;
    logic [P_WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;

    logic [4:0]         add_a_s;
    logic [6:0]         sum_s;

    // Partial product is added only when the current multiplier bit is set.
    assign add_a_s = q_q[0] ? m_q : 5'd0;

    Add5BitWith6Bit u_add (
        .a_i   (add_a_s),
        .b_i   (acc_q),
        .sum_o (sum_s)
    );

    // Next-state, datapath update and completion pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        p_d     = p_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    m_d     = bus.a_i;
                    q_d     = bus.b_i;
                    acc_d   = 6'd0;
                    count_d = 3'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else begin
                    // ACC never exceeds 31 before an add, so sum_s[6] is zero
                    // and the full sum shifted right is the new accumulator.
                    acc_d   = sum_s[6:1];
                    q_d     = {sum_s[0], q_q[4:1]};
                    count_d = count_q + 3'd1;
                    if (count_q == 3'(N_STEPS - 1)) begin
                        // {acc_next[4:0], q_next} folded directly from the sum.
                        p_d     = {sum_s[5:0], q_q[4:1]};
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                // Back-to-back issue: a start here reloads without an idle cycle.
                if (bus.start_i) begin
                    m_d     = bus.a_i;
                    q_d     = bus.b_i;
                    acc_d   = 6'd0;
                    count_d = 3'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 3'd0;
            m_q     <= 5'd0;
            q_q     <= 5'd0;
            acc_q   <= 6'd0;
            p_q     <= {P_WIDTH{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy_o  = (state_q == RUN);
    assign bus.done_o  = done_q;
    assign bus.p_o     = p_q;

endmodule

// File: tb/tb_seq_mul5_ctrl.sv
// Self-checking bench for seq_mul5_ctrl: table of directed operations,
// hand-written multi-cycle corner cases and a shuffled sweep of all operand
// pairs, all compared against a cycle-level behavioural model.
module tb_seq_mul5_ctrl;
    import mul5_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_mul5_ctrl_if bus ();

    seq_mul5_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: cycles left until DONE (0 = accepting), done flag,
    // expected product register and the product of the operation in flight.
    int run_left = 0;
    int done_m   = 0;
    int p_exp    = 0;
    int pend_p   = 0;
    int n_accept = 0;
    int n_done   = 0;

    typedef struct {
        int a;
        int b;
        int p;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        run_left = 0;
        done_m   = 0;
        p_exp    = 0;
    endtask

    // Called at a negedge: drive inputs, advance one clock, update the model,
    // then compare all outputs at the following negedge.
    task automatic cycle(input int s, input int ab, input int a, input int b);
        bus.start_i = s[0];
        bus.abort_i = ab[0];
        bus.a_i     = a[4:0];
        bus.b_i     = b[4:0];
        @(posedge clk);
        if (run_left > 0) begin
            done_m = 0;
            if (ab != 0) begin
                run_left = 0;
            end else begin
                run_left--;
                if (run_left == 0) begin
                    done_m = 1;
                    p_exp  = pend_p;
                end
            end
        end else begin
            done_m = 0;
            if (s != 0) begin
                pend_p   = a * b;
                run_left = N_STEPS;
                n_accept++;
            end
        end
        @(negedge clk);
        chk("ready", int'(bus.ready_o), int'(run_left == 0));
        chk("busy", int'(bus.busy_o), int'(run_left > 0));
        chk("done", int'(bus.done_o), done_m);
        chk("p", int'(bus.p_o), p_exp);
        if (bus.done_o) n_done++;
        if (bus.busy_o) chk("sum6", int'(dut.sum_s[6]), 0);
    endtask

    // Issue one table operation from a ready state and check latency,
    // busy length and product directly against the table.
    task automatic run_op(input int idx);
        int lat;
        int pv;
        int nbusy;
        lat = -1;
        pv  = -1;
        cycle(1, 0, vecs[idx].a, vecs[idx].b);
        nbusy = int'(bus.busy_o);
        for (int k = 1; k <= 9; k++) begin
            cycle(0, 0, $urandom_range(0, 31), $urandom_range(0, 31));
            if (bus.busy_o) nbusy++;
            if (bus.done_o && lat < 0) begin
                lat = k + 1;
                pv  = int'(bus.p_o);
            end
        end
        chk($sformatf("lat_%0dx%0d", vecs[idx].a, vecs[idx].b), lat, 6);
        chk($sformatf("prod_%0dx%0d", vecs[idx].a, vecs[idx].b), pv, vecs[idx].p);
        chk($sformatf("busy_%0dx%0d", vecs[idx].a, vecs[idx].b), nbusy, 5);
    endtask

    initial begin
        int lat_q[$];
        int p_q[$];
        int order[1024];
        int tmp;
        int j;
        int guard;
        int nd;

        vecs[0]  = '{13, 11, 143};
        vecs[1]  = '{31, 31, 961};
        vecs[2]  = '{0, 31, 0};
        vecs[3]  = '{31, 0, 0};
        vecs[4]  = '{7, 9, 63};
        vecs[5]  = '{31, 1, 31};
        vecs[6]  = '{3, 4, 12};
        vecs[7]  = '{2, 3, 6};
        vecs[8]  = '{1, 1, 1};
        vecs[9]  = '{25, 25, 625};
        vecs[10] = '{20, 20, 400};

        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.a_i     = 5'd0;
        bus.b_i     = 5'd0;

        // Reset state.
        #1;
        chk("rst_ready", int'(bus.ready_o), 1);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_p", int'(bus.p_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Directed table.
        for (int i = 0; i < 11; i++) run_op(i);

        // Back-to-back with start held: (7,9) then (31,1) accepted in DONE.
        cycle(1, 0, 7, 9);
        for (int k = 1; k <= 14; k++) begin
            if (k <= 6) cycle(1, 0, 31, 1);
            else        cycle(0, 0, 0, 0);
            if (bus.done_o) begin
                lat_q.push_back(k + 1);
                p_q.push_back(int'(bus.p_o));
            end
        end
        chk("b2b_count", lat_q.size(), 2);
        if (lat_q.size() == 2) begin
            chk("b2b_lat0", lat_q[0], 6);
            chk("b2b_lat1", lat_q[1], 12);
            chk("b2b_p0", p_q[0], 63);
            chk("b2b_p1", p_q[1], 31);
        end

        // Start during RUN is ignored.
        nd = n_done;
        cycle(1, 0, 3, 4);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 5, 5);
        for (int k = 3; k <= 12; k++) cycle(0, 0, 0, 0);
        chk("ignored_start_dones", n_done - nd, 1);
        chk("ignored_start_p", int'(bus.p_o), 12);

        // Abort at t+3 of (20,20): idle at t+4, no DONE, P kept.
        nd = n_done;
        cycle(1, 0, 20, 20);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("abort_ready", int'(bus.ready_o), 1);
        chk("abort_busy", int'(bus.busy_o), 0);
        for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0);
        chk("abort_dones", n_done - nd, 0);
        chk("abort_p_kept", int'(bus.p_o), 12);
        run_op(7);

        // Reset in the middle of (25,25).
        cycle(1, 0, 25, 25);
        cycle(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", int'(bus.ready_o), 1);
        chk("mid_rst_busy", int'(bus.busy_o), 0);
        chk("mid_rst_done", int'(bus.done_o), 0);
        chk("mid_rst_p", int'(bus.p_o), 0);
        model_reset();
        @(negedge clk);
        chk("mid_rst_hold_p", int'(bus.p_o), 0);
        rst_n = 1'b1;
        run_op(8);

        // Shuffled sweep of every operand pair with random ignored starts.
        for (int i = 0; i < 1024; i++) order[i] = i;
        for (int i = 1023; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        n_accept = 0;
        n_done   = 0;
        for (int i = 0; i < 1024; i++) begin
            guard = 0;
            while (run_left != 0 && guard < 20) begin
                cycle($urandom_range(0, 1), 0, $urandom_range(0, 31), $urandom_range(0, 31));
                guard++;
            end
            if (guard >= 20) chk("sweep_timeout", guard, 0);
            if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0);
            cycle(1, 0, order[i] / 32, order[i] % 32);
        end
        for (int k = 0; k < 8; k++) cycle(0, 0, 0, 0);
        chk("sweep_accepts", n_accept, 1024);
        chk("sweep_done_per_start", n_done, n_accept);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
